// File: rtl/pipe_muldiv_unit_if.sv
// Multiply/divide unit bundle: op launch, HI/LO moves, status and results.
// The pipeline controller is the master; the unit is the slave.
interface pipe_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    output flush, wr_hi, wr_lo, wdata,
    input  busy, done, div_zero,
    input  hi, lo
  );

  modport slave (
    input  start, op, a, b,
    input  flush, wr_hi, wr_lo, wdata,
    output busy, done, div_zero,
    output hi, lo
  );
endinterface

// File: rtl/pipe_muldiv_unit.sv
// Iterative mult/multu/div/divu unit with HI/LO registers.
// Magnitudes run through an unsigned shift-add / restoring core.
module pipe_muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input logic               clk_i,
  input logic               reset_i,
  pipe_muldiv_unit_if.slave bus
);
  localparam int ITER = WIDTH / UNROLL;
  localparam int CW   = $clog2(ITER + 1);
  localparam int AW   = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dzf_q, dzf_d;

  logic             sgn;
  logic [WIDTH-1:0] ma, mbv;
  logic [AW-1:0]    step;
  logic [WIDTH:0]   part;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mb_q     <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dzf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mb_q     <= mb_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dzf_q    <= dzf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mb_d     = mb_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dzf_d    = 1'b0;
    sgn      = 1'b0;
    ma       = '0;
    mbv      = '0;
    step     = acc_q;
    part     = '0;
    prod     = '0;
    quo      = '0;
    rem      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.wr_hi) hi_d = bus.wdata;
        if (bus.wr_lo) lo_d = bus.wdata;
        if (bus.start && !bus.flush) begin
          sgn = !bus.op[0];
          ma  = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          mbv = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          state_d  = S_RUN;
          cnt_d    = CW'(ITER);
          mb_d     = mbv;
          araw_d   = bus.a;
          is_div_d = bus.op[1];
          neg_d    = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          negr_d   = sgn && bus.a[WIDTH-1];
          dz_d     = bus.op[1] && (bus.b == '0);
          acc_d    = {{(WIDTH+1){1'b0}}, ma};
        end
      end
      S_RUN: begin
        // div: remainder grows in the top half, quotient fills from bit 0
        for (int i = 0; i < UNROLL; i++) begin
          if (is_div_q) begin
            step = step << 1;
            if (step[AW-1:WIDTH] >= {1'b0, mb_q}) begin
              step[AW-1:WIDTH] = step[AW-1:WIDTH] - {1'b0, mb_q};
              step[0] = 1'b1;
            end
          end else begin
            part = {1'b0, step[2*WIDTH-1:WIDTH]}
                 + (step[0] ? {1'b0, mb_q} : '0);
            step = {1'b0, part, step[WIDTH-1:1]};
          end
        end
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          dzf_d  = dz_q;
          if (!is_div_q) begin
            prod = acc_q[2*WIDTH-1:0];
            if (neg_q) prod = -prod;
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            quo = acc_q[WIDTH-1:0];
            rem = acc_q[2*WIDTH-1:WIDTH];
            if (neg_q)  quo = -quo;
            if (negr_q) rem = -rem;
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dzf_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Bench for pipe_muldiv_unit: UNROLL=1 and UNROLL=4 instances
// checked against a plain-arithmetic HI/LO model.
module tb_pipe_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic start, flush, wr_hi, wr_lo, sel4;
  logic [1:0] op;
  logic [W-1:0] a, b, wdata;
  logic busy_o, done_o, dz_o;
  logic [W-1:0] hi_o, lo_o;
  int checks = 0;
  int errors = 0;

  pipe_muldiv_unit_if #(.WIDTH(W)) bus1 ();
  pipe_muldiv_unit_if #(.WIDTH(W)) bus4 ();

  assign bus1.start = start & ~sel4;
  assign bus1.flush = flush & ~sel4;
  assign bus1.wr_hi = wr_hi & ~sel4;
  assign bus1.wr_lo = wr_lo & ~sel4;
  assign bus1.op    = op;
  assign bus1.a     = a;
  assign bus1.b     = b;
  assign bus1.wdata = wdata;
  assign bus4.start = start & sel4;
  assign bus4.flush = flush & sel4;
  assign bus4.wr_hi = wr_hi & sel4;
  assign bus4.wr_lo = wr_lo & sel4;
  assign bus4.op    = op;
  assign bus4.a     = a;
  assign bus4.b     = b;
  assign bus4.wdata = wdata;

  assign busy_o = sel4 ? bus4.busy : bus1.busy;
  assign done_o = sel4 ? bus4.done : bus1.done;
  assign dz_o   = sel4 ? bus4.div_zero : bus1.div_zero;
  assign hi_o   = sel4 ? bus4.hi : bus1.hi;
  assign lo_o   = sel4 ? bus4.lo : bus1.lo;

  pipe_muldiv_unit #(.WIDTH(W), .UNROLL(1)) u1 (
    .clk_i(clk), .reset_i(reset), .bus(bus1)
  );
  pipe_muldiv_unit #(.WIDTH(W), .UNROLL(4)) u4 (
    .clk_i(clk), .reset_i(reset), .bus(bus4)
  );

  always #5 clk = ~clk;

  // Returns {div_zero, hi, lo}
  function automatic logic [2*W:0] model(input logic [1:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    logic [2*W-1:0] r;
    logic dz;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    dz = 1'b0;
    case (o)
      2'b00: r = sx * sy;
      2'b01: r = ux * uy;
      2'b10: begin
        if (y == 0) begin
          dz = 1'b1;
          r = {x, 32'hFFFF_FFFF};
        end else begin
          r = {32'(sx % sy), 32'(sx / sy)};
        end
      end
      default: begin
        if (y == 0) begin
          dz = 1'b1;
          r = {x, 32'hFFFF_FFFF};
        end else begin
          r = {32'(ux % uy), 32'(ux / uy)};
        end
      end
    endcase
    return {dz, r};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 4))
        0: v = 32'h0;
        1: v = 32'h1;
        2: v = 32'hFFFF_FFFF;
        3: v = 32'h8000_0000;
        default: v = 32'h7FFF_FFFF;
      endcase
    end else begin
      v = $urandom;
    end
    return v;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input string nm);
    logic [2*W:0] e;
    int iter, dc;
    logic bbad;
    e = model(o, x, y);
    iter = sel4 ? W / 4 : W;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    bbad = 1'b0;
    for (int c = 1; c <= iter + 10 && dc == 0; c++) begin
      if (done_o === 1'b1) begin
        dc = c;
      end else begin
        if (busy_o !== (c <= iter + 1)) bbad = 1'b1;
        @(negedge clk);
      end
    end
    checks++;
    if (dc != iter + 2) begin
      errors++;
      $display("FAIL %s done_cycle got %0d want %0d", nm, dc, iter + 2);
    end
    checks++;
    if (bbad) begin
      errors++;
      $display("FAIL %s busy_window got wrong want busy in 1..%0d", nm, iter + 1);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done got %b want 0", nm, busy_o);
    end
    checks++;
    if ({dz_o, hi_o, lo_o} !== e) begin
      errors++;
      $display("FAIL %s result got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
               nm, dz_o, hi_o, lo_o, e[2*W], e[2*W-1:W], e[W-1:0]);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || {hi_o, lo_o} !== e[2*W-1:0]) begin
      errors++;
      $display("FAIL %s after_done got done=%b hi=%h lo=%h want done=0 hi=%h lo=%h",
               nm, done_o, hi_o, lo_o, e[2*W-1:W], e[W-1:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus1.busy, bus1.done, bus1.div_zero, bus1.hi, bus1.lo} !== '0) begin
      errors++;
      $display("FAIL reset_u1 got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               bus1.busy, bus1.done, bus1.div_zero, bus1.hi, bus1.lo);
    end
    checks++;
    if ({bus4.busy, bus4.done, bus4.div_zero, bus4.hi, bus4.lo} !== '0) begin
      errors++;
      $display("FAIL reset_u4 got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               bus4.busy, bus4.done, bus4.div_zero, bus4.hi, bus4.lo);
    end
  endtask

  task automatic test_directed();
    sel4 = 1'b0;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, "divu_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, "div_negb");
    run_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, "div_zero_neg");
  endtask

  task automatic test_random(input int n, input logic s4);
    @(negedge clk);
    sel4 = s4;
    for (int i = 0; i < n; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(),
             s4 ? "rand_u4" : "rand_u1");
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [2*W:0] e;
    @(negedge clk);
    sel4 = 1'b0;
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hC0DE_0001;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    checks++;
    if (hi_o !== 32'hC0DE_0001 || lo_o !== 32'hC0DE_0001) begin
      errors++;
      $display("FAIL mt_both got hi=%h lo=%h want C0DE0001", hi_o, lo_o);
    end
    wr_hi = 1'b1; wdata = 32'h0000_BEEF;
    @(negedge clk);
    wr_hi = 1'b0;
    checks++;
    if (hi_o !== 32'h0000_BEEF || lo_o !== 32'hC0DE_0001) begin
      errors++;
      $display("FAIL mthi got hi=%h lo=%h want hi=0000BEEF lo=C0DE0001", hi_o, lo_o);
    end
    wr_lo = 1'b1; wdata = 32'h1357_9BDF;
    @(negedge clk);
    wr_lo = 1'b0;
    checks++;
    if (hi_o !== 32'h0000_BEEF || lo_o !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL mtlo got hi=%h lo=%h want hi=0000BEEF lo=13579BDF", hi_o, lo_o);
    end
    e = model(2'b11, 32'd100, 32'd7);
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    wr_lo = 1'b1; wdata = 32'h0000_4444;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    checks++;
    if (lo_o !== 32'h0000_4444 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mtlo_with_start got lo=%h busy=%b want lo=00004444 busy=1",
               lo_o, busy_o);
    end
    repeat (W + 1) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || {hi_o, lo_o} !== e[2*W-1:0]) begin
      errors++;
      $display("FAIL start_overwrites got done=%b hi=%h lo=%h want done=1 hi=%h lo=%h",
               done_o, hi_o, lo_o, e[2*W-1:W], e[W-1:0]);
    end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    sel4 = 1'b0;
    wr_hi = 1'b1; wdata = 32'h1111_2222;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h3333_4444;
    @(negedge clk);
    wr_lo = 1'b0;
    op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || hi_o !== 32'h1111_2222 || lo_o !== 32'h3333_4444) begin
      errors++;
      $display("FAIL flush_run got busy=%b hi=%h lo=%h want busy=0 hi=11112222 lo=33334444",
               busy_o, hi_o, lo_o);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || hi_o !== 32'h1111_2222 || lo_o !== 32'h3333_4444) begin
      errors++;
      $display("FAIL flush_quiet got activity=%b hi=%h lo=%h want 0 11112222 33334444",
               seen, hi_o, lo_o);
    end
    run_op(2'b01, 32'd5, 32'd6, "after_flush");
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = busy_o;
    repeat (40) begin
      @(negedge clk);
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || lo_o !== 32'd30) begin
      errors++;
      $display("FAIL flush_start got activity=%b lo=%h want 0 lo=0000001e", seen, lo_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W:0] e;
    int dc;
    @(negedge clk);
    sel4 = 1'b0;
    wr_lo = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    wr_lo = 1'b0;
    e = model(2'b00, 32'hFFFF_1234, 32'h0000_0077);
    op = 2'b00; a = 32'hFFFF_1234; b = 32'h0000_0077; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b11; a = 32'h0000_FFFF; b = 32'd3; start = 1'b1;
    wr_lo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || lo_o !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL busy_ignore got busy=%b lo=%h want busy=1 lo=0badf00d", busy_o, lo_o);
    end
    dc = 0;
    for (int c = 6; c <= 60 && dc == 0; c++) begin
      if (done_o === 1'b1) dc = c;
      else @(negedge clk);
    end
    checks++;
    if (dc != W + 2 || {dz_o, hi_o, lo_o} !== e) begin
      errors++;
      $display("FAIL start_ignored got cyc=%0d hi=%h lo=%h want cyc=%0d hi=%h lo=%h",
               dc, hi_o, lo_o, W + 2, e[2*W-1:W], e[W-1:0]);
    end
  endtask

  task automatic test_unroll4();
    @(negedge clk);
    sel4 = 1'b1;
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, "u4_multu");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "u4_div");
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, "u4_divzero");
    op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy_o, done_o, dz_o, hi_o, lo_o} !== '0) begin
      errors++;
      $display("FAIL u4_reset_midop got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               busy_o, done_o, dz_o, hi_o, lo_o);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; flush = 1'b0;
    wr_hi = 1'b0; wr_lo = 1'b0;
    sel4 = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_flush();
    test_back_to_back();
    test_random(40, 1'b0);
    test_unroll4();
    test_random(30, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
